// File: rtl/synth_pkg.sv
// Shared constants and types for the PWM audio output path.
package synth_pkg;

   localparam int SAMPLE_W         = 8;
   localparam int PWM_W            = 8;
   localparam int PRESCALE_DEFAULT = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE clocks while not cleared.
module tick_gen
   import synth_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEFAULT
) (
   input  logic clk,
   input  logic nRst,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = cntWidth(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
         tick  = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: double-buffers mixer samples and converts them to a
// registered PWM bit, one sample per 256-step PWM frame.
module pwm_audio_out
   import synth_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEFAULT
) (
   input  logic                clk,
   input  logic                nRst,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_req,
   output logic                pwm_out,
   output logic                underrun
);

   state_e state_q, state_d;

   logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
   logic [SAMPLE_W-1:0] duty_q, duty_d;
   logic [SAMPLE_W-1:0] buf_q, buf_d;
   logic                buf_full_q, buf_full_d;
   logic                pwm_q, pwm_d;
   logic                req_q, req_d;
   logic                underrun_q, underrun_d;

   logic active;
   logic startRun;
   logic tick;
   logic frameEnd;

   // A RUN cycle with en low already behaves as IDLE so the drop takes effect at once.
   assign active   = (state_q == RUN) && en;
   assign startRun = (state_q == IDLE) && en;
   assign frameEnd = tick && (pwm_cnt_q == '1);

   tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .nRst (nRst),
      .clear(!active),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      if (en) begin
         state_d = RUN;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      pwm_cnt_d  = pwm_cnt_q;
      duty_d     = duty_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      pwm_d      = 1'b0;
      req_d      = 1'b0;
      underrun_d = underrun_q;

      if (!active) begin
         pwm_cnt_d  = '0;
         duty_d     = '0;
         buf_d      = '0;
         buf_full_d = 1'b0;
         if (startRun) begin
            underrun_d = 1'b0;
            req_d      = 1'b1;
         end
      end else begin
         pwm_d = (pwm_cnt_q < duty_q);
         if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
         end
         // A sample arriving exactly at frame end bypasses the buffer.
         if (frameEnd) begin
            req_d = 1'b1;
            if (sample_valid) begin
               duty_d     = sample_in;
               buf_full_d = 1'b0;
            end else if (buf_full_q) begin
               duty_d     = buf_q;
               buf_full_d = 1'b0;
            end else begin
               underrun_d = 1'b1;
            end
         end else if (sample_valid) begin
            buf_d      = sample_in;
            buf_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         pwm_cnt_q  <= '0;
         duty_q     <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         pwm_q      <= 1'b0;
         req_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         duty_q     <= duty_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         pwm_q      <= pwm_d;
         req_q      <= req_d;
         underrun_q <= underrun_d;
      end
   end

   assign sample_req = req_q;
   assign pwm_out    = pwm_q;
   assign underrun   = underrun_q;

endmodule
